tff_count_ctrl: RTL and testbench
=================================

Name: tff_count_ctrl

Overview:
- Sequencer for a WIDTH-bit bank of T flip-flops used as a programmable counter.
- Per cycle, computes the toggle vector for the bank (up, down, load, wrap or hold) and owns the bank's q/qb state.
- Runs a small FSM with a start/done handshake, pause and abort.
- Sits beside t_ff-style datapaths as the block that sequences toggle enables instead of driving each t input by hand.

Parameters:
- WIDTH, 4, number of T flip-flops in the bank (>= 2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin counting (level sampled each edge)
- pause  input  1  freeze bank while high (RUN <-> PAUSE)
- abort  input  1  return to IDLE from any state, q held
- dir  input  1  1 = up, 0 = down; sampled when RUN is entered
- wrap_en  input  1  1 = wrap at terminal count, 0 = stop in DONE; sampled when RUN is entered
- load  input  1  load load_val into bank (IDLE/PAUSE only)
- load_val  input  WIDTH  value to load
- limit  input  WIDTH  terminal count (up) / reload value (down)
- t_vec  output  WIDTH  toggle vector applied to the bank this cycle (combinational)
- q  output  WIDTH  bank state
- qb  output  WIDTH  ~q
- busy  output  1  high in RUN or PAUSE
- done  output  1  high in DONE
- wrap  output  1  one-cycle pulse, registered, on the cycle after a wrap edge

Behaviour:
- Bank update: q <= q ^ t_vec every edge; q only ever changes through t_vec.
- Reset (asynchronous, active-high): state=IDLE, q=0, qb=all-ones, busy=0, done=0, wrap=0; dir_r=1, wrap_r=0.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Priority on every edge: abort > load > start/pause.
- IDLE:
  - load -> t_vec=q^load_val; stay in IDLE.
  - else start -> RUN; capture dir_r, wrap_r; t_vec=0 on this edge.
  - else t_vec=0.
- RUN, normal counting:
  - Up: t_vec[0]=1, t_vec[i]=&q[i-1:0].
  - Down: t_vec[0]=1, t_vec[i]=&(~q[i-1:0]).
- RUN, terminal count (up: q==limit; down: q==0):
  - wrap_r=1: t_vec=q^0 (up) or q^limit (down); wrap=1 next cycle; stay in RUN.
  - wrap_r=0: t_vec=0; -> DONE.
- RUN, pause=1: t_vec=0; -> PAUSE. Pause outranks terminal count on the same edge.
- PAUSE:
  - t_vec=0.
  - load applies q^load_val and stays in PAUSE.
  - pause=0 -> RUN.
- DONE:
  - done=1, q held.
  - start -> RUN; reinitialise q to 0 (up) or limit (down) via t_vec; recapture dir_r/wrap_r.
  - abort -> IDLE.
- abort, any state: -> IDLE next edge; t_vec=0; busy/done low on the next cycle.
- load and start asserted together in IDLE: load wins; start is ignored that edge.
- q loaded above limit when counting up: count passes through 2^WIDTH-1 -> 0 by natural rollover (no wrap pulse), then stops or wraps at limit.
- limit=0 when counting up: terminal count on the first RUN edge.
- Latency: start edge -> first increment on the following edge.
- Reset asserted mid-count: all state clears immediately, with no clock edge required.

Optional Feature:
- Macro: TFF_CTRL_GRAY_EN.
- Defined: adds output gray [WIDTH-1:0] = q ^ (q >> 1), registered (one cycle behind q), reset to 0.
- Not defined: port absent; no extra logic.

Test Plan:
- Reset: hold reset with clk stopped -> q=0000, qb=1111, busy=0, done=0, wrap=0.
- Up count, stop: WIDTH=4, limit=5, dir=1, wrap_en=0, start one cycle -> q goes 1,2,3,4,5 on consecutive edges; done=1 the cycle after q=5; q stays 5; t_vec at q=3 equals 0111.
- Down count, wrap: load 2, limit=9, dir=0, wrap_en=1, start -> q goes 1,0,9,8; wrap=1 for exactly one cycle after the 0->9 edge.
- Pause and load: while running up at q=6, pause=1 for 3 cycles with load_val=12 and load=1 on the 2nd cycle -> q holds 6, becomes 12, holds; release pause -> 13.
- Abort and priority: in RUN at q=7, assert abort, load and start together -> IDLE, q stays 7, busy=0. Then load and start together in IDLE with load_val=3 -> q=3, state stays IDLE.
- Rollover past limit: load 14, limit=1, dir=1, wrap_en=0, start -> q goes 15,0,1 then DONE; no wrap pulse. With TFF_CTRL_GRAY_EN defined, gray=0001 one cycle after q=1.

Source files
------------

// File: rtl/tff_count_ctrl.sv
// -----------------------------------------------------------------------------
// tff_count_ctrl
//
// Sequencer for a WIDTH-bit bank of T flip-flops used as a programmable
// counter. Each cycle it computes the toggle vector for the bank (count up,
// count down, load, wrap or hold) and owns the bank state, so q only ever
// changes as q <= q ^ t_vec. A small FSM (IDLE/RUN/PAUSE/DONE) provides a
// start/done handshake with pause and abort.
//
// Priority on every edge: abort > load > start/pause.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   start     in   begin counting (level, sampled each edge)
//   pause     in   freeze the bank while high (RUN <-> PAUSE)
//   abort     in   return to IDLE from any state, q held
//   dir       in   1 = up, 0 = down; captured when RUN is entered
//   wrap_en   in   1 = wrap at terminal count, 0 = stop in DONE; captured
//                  when RUN is entered
//   load      in   load load_val into the bank (IDLE/PAUSE only)
//   load_val  in   [WIDTH-1:0] value to load
//   limit     in   [WIDTH-1:0] terminal count (up) / reload value (down)
//   t_vec     out  [WIDTH-1:0] toggle vector applied this cycle (comb)
//   q         out  [WIDTH-1:0] bank state
//   qb        out  [WIDTH-1:0] ~q
//   busy      out  high in RUN or PAUSE
//   done      out  high in DONE
//   wrap      out  one-cycle registered pulse after a wrap edge
//   gray      out  [WIDTH-1:0] registered q ^ (q >> 1), one cycle behind q
//                  (present only when TFF_CTRL_GRAY_EN is defined)
//
// Build option: define TFF_CTRL_GRAY_EN to add the gray output.
// -----------------------------------------------------------------------------
module tff_count_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic             dir,
   input  logic             wrap_en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] t_vec,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             busy,
   output logic             done,
   output logic             wrap
`ifdef TFF_CTRL_GRAY_EN
   ,
   output logic [WIDTH-1:0] gray
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] bank_q, bank_d;
   logic [WIDTH-1:0] qb_q;
   logic             dir_q, dir_d;
   logic             wrap_en_q, wrap_en_d;
   logic             wrap_q, wrap_d;
   logic             busy_q, done_q;
   logic [WIDTH-1:0] up_t_s, dn_t_s;
   logic             at_term_s;

`ifdef TFF_CTRL_GRAY_EN
   logic [WIDTH-1:0] gray_q;
`endif

   // Counting toggle vectors: bit i toggles when all lower bits are 1 (up)
   // or all lower bits are 0 (down); built as a running AND chain.
   always_comb begin : count_vec
      logic up_acc;
      logic dn_acc;
      up_acc = 1'b1;
      dn_acc = 1'b1;
      up_t_s = {WIDTH{1'b0}};
      dn_t_s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         up_t_s[i] = up_acc;
         dn_t_s[i] = dn_acc;
         up_acc    = up_acc & bank_q[i];
         dn_acc    = dn_acc & ~bank_q[i];
      end
   end

   // Terminal count uses the direction captured on RUN entry.
   assign at_term_s = dir_q ? (bank_q == limit) : (bank_q == {WIDTH{1'b0}});

   // Next-state, toggle vector and captured-mode logic.
   always_comb begin
      state_d   = state_q;
      t_vec     = {WIDTH{1'b0}};
      dir_d     = dir_q;
      wrap_en_d = wrap_en_q;
      wrap_d    = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load) begin
                  t_vec = bank_q ^ load_val;
               end else if (start) begin
                  state_d   = ST_RUN;
                  dir_d     = dir;
                  wrap_en_d = wrap_en;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               // Pause outranks a terminal count on the same edge.
               if (pause) begin
                  state_d = ST_PAUSE;
               end else if (at_term_s) begin
                  if (wrap_en_q) begin
                     t_vec  = dir_q ? bank_q : (bank_q ^ limit);
                     wrap_d = 1'b1;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  t_vec = dir_q ? up_t_s : dn_t_s;
               end
            end
            ST_PAUSE: begin
               if (load) begin
                  t_vec = bank_q ^ load_val;
               end else if (!pause) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_PAUSE;
               end
            end
            ST_DONE: begin
               // Restart reinitialises the bank using the freshly sampled dir.
               if (start) begin
                  state_d   = ST_RUN;
                  dir_d     = dir;
                  wrap_en_d = wrap_en;
                  t_vec     = dir ? bank_q : (bank_q ^ limit);
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign bank_d = bank_q ^ t_vec;

   // State, bank and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bank_q    <= {WIDTH{1'b0}};
         qb_q      <= {WIDTH{1'b1}};
         dir_q     <= 1'b1;
         wrap_en_q <= 1'b0;
         wrap_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bank_q    <= bank_d;
         qb_q      <= ~bank_d;
         dir_q     <= dir_d;
         wrap_en_q <= wrap_en_d;
         wrap_q    <= wrap_d;
         busy_q    <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
         done_q    <= (state_d == ST_DONE);
      end
   end

`ifdef TFF_CTRL_GRAY_EN
   // Gray code of the bank, one cycle behind q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gray_q <= {WIDTH{1'b0}};
      end else begin
         gray_q <= bank_q ^ (bank_q >> 1);
      end
   end

   assign gray = gray_q;
`endif

   assign q    = bank_q;
   assign qb   = qb_q;
   assign busy = busy_q;
   assign done = done_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tff_count_ctrl
//
// Self-checking bench for tff_count_ctrl (WIDTH = 4). A behavioural model
// keeps the counter as an integer and advances it with plain modular
// arithmetic; every cycle the DUT outputs and the toggle vector (old q XOR
// new q) are compared against it. Directed scenarios are followed by a
// randomized phase that includes an asynchronous mid-run reset.
// -----------------------------------------------------------------------------
module tb_tff_count_ctrl;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk;
   logic         clk_en;
   logic         reset;
   logic         start, pause, abort, dir, wrap_en, load;
   logic [W-1:0] load_val, limit;
   logic [W-1:0] t_vec, q, qb;
   logic         busy, done, wrap;
`ifdef TFF_CTRL_GRAY_EN
   logic [W-1:0] gray;
`endif

   int n_cmp;
   int n_err;

   // model state: 0 idle, 1 run, 2 pause, 3 done
   int m_st, m_q, m_dir, m_wen, m_wp, m_gray;
   int n_st, n_q, n_dir, n_wen, n_wp;

   tff_count_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .pause    (pause),
      .abort    (abort),
      .dir      (dir),
      .wrap_en  (wrap_en),
      .load     (load),
      .load_val (load_val),
      .limit    (limit),
      .t_vec    (t_vec),
      .q        (q),
      .qb       (qb),
      .busy     (busy),
      .done     (done),
      .wrap     (wrap)
`ifdef TFF_CTRL_GRAY_EN
      ,
      .gray     (gray)
`endif
   );

   // Clock only runs once enabled so reset can be checked with clk stopped.
   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   task automatic set_in(input logic s, input logic p, input logic a, input logic d,
                         input logic w, input logic l, input int lv, input int lim);
      start    = s;
      pause    = p;
      abort    = a;
      dir      = d;
      wrap_en  = w;
      load     = l;
      load_val = W'(lv);
      limit    = W'(lim);
   endtask

   task automatic model_reset();
      m_st   = 0;
      m_q    = 0;
      m_dir  = 1;
      m_wen  = 0;
      m_wp   = 0;
      m_gray = 0;
   endtask

   // Next model state from the counter rules, using integer arithmetic.
   task automatic model_next();
      int lv, lim;
      lv    = int'(load_val);
      lim   = int'(limit);
      n_st  = m_st;
      n_q   = m_q;
      n_dir = m_dir;
      n_wen = m_wen;
      n_wp  = 0;
      if (abort) begin
         n_st = 0;
      end else if (m_st == 0) begin
         if (load) n_q = lv;
         else if (start) begin
            n_st = 1; n_dir = int'(dir); n_wen = int'(wrap_en);
         end
      end else if (m_st == 1) begin
         if (pause) n_st = 2;
         else if ((m_dir != 0) ? (m_q == lim) : (m_q == 0)) begin
            if (m_wen != 0) begin
               n_q  = (m_dir != 0) ? 0 : lim;
               n_wp = 1;
            end else n_st = 3;
         end else begin
            n_q = (m_dir != 0) ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
         end
      end else if (m_st == 2) begin
         if (load) n_q = lv;
         else if (!pause) n_st = 1;
      end else begin
         if (start) begin
            n_st = 1; n_dir = int'(dir); n_wen = int'(wrap_en);
            n_q  = dir ? 0 : lim;
         end
      end
   endtask

   // One clock cycle: inputs already driven after a negedge.
   task automatic cycle();
      model_next();
      #1;
      chk("t_vec", 32'(t_vec), 32'(m_q ^ n_q));
      chk("q",     32'(q),     32'(m_q));
      chk("qb",    32'(qb),    32'((~m_q) & (MOD - 1)));
      chk("busy",  32'(busy),  32'(m_st == 1 || m_st == 2));
      chk("done",  32'(done),  32'(m_st == 3));
      chk("wrap",  32'(wrap),  32'(m_wp));
`ifdef TFF_CTRL_GRAY_EN
      chk("gray",  32'(gray),  32'(m_gray));
`endif
      @(posedge clk);
      m_gray = m_q ^ (m_q >> 1);
      m_st   = n_st;
      m_q    = n_q;
      m_dir  = n_dir;
      m_wen  = n_wen;
      m_wp   = n_wp;
      @(negedge clk);
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      clk_en = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      model_reset();

      // Reset with the clock stopped.
      reset = 1'b1;
      #3;
      chk("rst_q",    32'(q),    32'(0));
      chk("rst_qb",   32'(qb),   32'(15));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_wrap", 32'(wrap), 32'(0));
      reset  = 1'b0;
      #1;
      clk_en = 1'b1;
      @(negedge clk);

      // Up count to limit 5, stop in DONE.
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 5);
      cycle();
      start = 1'b0;
      cycles(6);
      chk("up_q",    32'(q),    32'(5));
      chk("up_done", 32'(done), 32'(1));
      cycles(2);
      abort = 1'b1;
      cycle();
      abort = 1'b0;

      // Down count with wrap: load 2, limit 9.
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 9);
      cycle();
      load  = 1'b0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycles(3);
      chk("dn_q9",   32'(q),    32'(9));
      chk("dn_wrap", 32'(wrap), 32'(1));
      cycle();
      chk("dn_q8",    32'(q),    32'(8));
      chk("dn_wrap0", 32'(wrap), 32'(0));
      abort = 1'b1;
      cycle();
      abort = 1'b0;

      // Pause and load while running up at q=6.
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 15);
      cycle();
      load  = 1'b0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycles(2);
      chk("pl_q6", 32'(q), 32'(6));
      pause = 1'b1;
      cycle();
      load_val = 4'd12;
      load     = 1'b1;
      cycle();
      load = 1'b0;
      cycle();
      chk("pl_q12", 32'(q), 32'(12));
      pause = 1'b0;
      cycles(2);
      chk("pl_q13", 32'(q), 32'(13));

      // Abort + load + start in RUN, then load + start in IDLE.
      abort = 1'b1;
      cycle();
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 15);
      cycle();
      load  = 1'b0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycles(2);
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9, 15);
      cycle();
      chk("ab_q",    32'(q),    32'(7));
      chk("ab_busy", 32'(busy), 32'(0));
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3, 15);
      cycle();
      chk("ls_q",    32'(q),    32'(3));
      chk("ls_busy", 32'(busy), 32'(0));

      // Rollover past the limit: load 14, limit 1.
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14, 1);
      cycle();
      load  = 1'b0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycles(4);
      chk("ro_q",    32'(q),    32'(1));
      chk("ro_done", 32'(done), 32'(1));
      cycle();

      // Randomized phase with an asynchronous mid-run reset.
      for (int it = 0; it < 600; it++) begin
         if (it == 300) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
            #2;
            reset = 1'b1;
            #1;
            chk("arst_q",    32'(q),    32'(0));
            chk("arst_qb",   32'(qb),   32'(15));
            chk("arst_busy", 32'(busy), 32'(0));
            chk("arst_done", 32'(done), 32'(0));
            chk("arst_wrap", 32'(wrap), 32'(0));
            reset = 1'b0;
            model_reset();
            @(negedge clk);
         end
         set_in(($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 24) == 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, MOD - 1)),
                int'($urandom_range(0, MOD - 1)));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
